score_bcd_counter: RTL and testbench

Multi-digit BCD score counter that produces the 4-bit BCD digit codes consumed by the per-digit seven-segment decoders on the HEX displays. Game logic raises `inc` once per pipe cleared; the block edge-detects it, increments a decimal score with ripple carry, saturates at all nines, and tracks a high score. Display outputs carry leading-zero blanking by substituting code 4'hF, which the decoder renders as all segments off.

---
 rtl/score_bcd_counter_if.sv | 23 ++
 rtl/score_bcd_counter.sv | 128 ++++++++++++
 tb/tb_score_bcd_counter.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/score_bcd_counter_if.sv
// Score counter bus: game-side request/clear inputs and BCD display outputs.
// Shared by the counter (slave) and whatever drives it (master).
interface score_bcd_counter_if #(
    parameter int DIGITS = 3
);
    logic                  inc;
    logic                  clear;
    logic [4*DIGITS-1:0]   score;
    logic [4*DIGITS-1:0]   disp;
    logic [4*DIGITS-1:0]   hi_disp;
    logic                  overflow;
    logic                  new_high;

    modport master (
        output inc, clear,
        input  score, disp, hi_disp, overflow, new_high
    );

    modport slave (
        input  inc, clear,
        output score, disp, hi_disp, overflow, new_high
    );
endinterface

// File: rtl/score_bcd_counter.sv
// Saturating multi-digit BCD score counter with leading-zero blanked display codes.
// High-score tracking is built only when SCORE_HISCORE_EN is defined.
module score_bcd_counter #(
    parameter int DIGITS = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    score_bcd_counter_if.slave   bus
);
    localparam int W = 4 * DIGITS;

    typedef enum logic {S_RUN, S_SAT} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_inc_q;
    logic [W-1:0]   r_score;
    logic [W-1:0]   w_score_nxt;
    logic [W-1:0]   w_score_inc;
    logic           r_ovf;
    logic           w_ovf_nxt;
    logic           w_all9;
    logic           w_carry;
    logic           w_inc_rise;

    assign w_inc_rise = bus.inc & ~r_inc_q;

    function automatic logic [W-1:0] f_blank(input logic [W-1:0] v);
        logic [W-1:0] o;
        logic         lead;
        o    = v;
        lead = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lead = lead & (v[4*i +: 4] == 4'd0);
            if (lead) o[4*i +: 4] = 4'hF;
        end
        return o;
    endfunction

    // Ripple-carry BCD increment; w_all9 flags the saturation point.
    always_comb begin
        w_score_inc = r_score;
        w_all9      = 1'b1;
        w_carry     = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_score[4*i +: 4] != 4'd9) w_all9 = 1'b0;
            if (w_carry) begin
                if (r_score[4*i +: 4] == 4'd9) begin
                    w_score_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_score_inc[4*i +: 4] = r_score[4*i +: 4] + 4'd1;
                    w_carry               = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_score_nxt = r_score;
        w_ovf_nxt   = r_ovf;
        if (bus.clear) begin
            w_state_nxt = S_RUN;
            w_score_nxt = '0;
            w_ovf_nxt   = 1'b0;
        end else begin
            unique case (r_state)
                S_RUN: begin
                    if (w_inc_rise) begin
                        if (w_all9) begin
                            w_state_nxt = S_SAT;
                            w_ovf_nxt   = 1'b1;
                        end else begin
                            w_score_nxt = w_score_inc;
                        end
                    end
                end
                S_SAT: begin
                    if (w_inc_rise) w_ovf_nxt = 1'b1;
                end
                default: w_state_nxt = S_RUN;
            endcase
        end
    end

    // inc_q resets high so a request held through reset release is ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_RUN;
            r_inc_q <= 1'b1;
            r_score <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_inc_q <= bus.inc;
            r_score <= w_score_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign bus.score    = r_score;
    assign bus.disp     = f_blank(r_score);
    assign bus.overflow = r_ovf;

`ifdef SCORE_HISCORE_EN
    logic [W-1:0]   r_hi;
    logic           r_new_high;

    // Packed BCD compares correctly as plain binary.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hi       <= '0;
            r_new_high <= 1'b0;
        end else if (r_score > r_hi) begin
            r_hi       <= r_score;
            r_new_high <= 1'b1;
        end else begin
            r_new_high <= 1'b0;
        end
    end

    assign bus.hi_disp  = f_blank(r_hi);
    assign bus.new_high = r_new_high;
`else
    assign bus.hi_disp  = {DIGITS{4'hF}};
    assign bus.new_high = 1'b0;
`endif
endmodule

// File: tb/tb_score_bcd_counter.sv
// Scoreboard bench for score_bcd_counter (DIGITS=3).
// Expected scores are queued as stimulus is driven and popped on output.
module tb_score_bcd_counter;
    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_bad;
    int   m_score;
    int   m_hi;
    bit   m_ovf;
    bit   m_nh;
    logic [11:0] q[$];
    logic [11:0] exp_v;

    score_bcd_counter_if #(.DIGITS(3)) bus ();

    score_bcd_counter #(.DIGITS(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] d2, d1, d0;
        d2 = 4'((v / 100) % 10);
        d1 = 4'((v / 10) % 10);
        d0 = 4'(v % 10);
        return {d2, d1, d0};
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        bus.inc = 1'b0;
        bus.clear = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        m_score = 0;
        m_hi = 0;
        m_ovf = 1'b0;
        m_nh = 1'b0;
        q.delete();
    endtask

    task automatic do_inc();
        @(negedge clk) bus.inc = 1'b1;
        @(negedge clk) bus.inc = 1'b0;
        if (m_score == 999) m_ovf = 1'b1;
        else m_score++;
        m_nh = (m_score > m_hi);
        if (m_nh) m_hi = m_score;
        q.push_back(to_bcd(m_score));
        @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk) bus.clear = 1'b1;
        @(negedge clk) bus.clear = 1'b0;
        m_score = 0;
        m_ovf = 1'b0;
        q.push_back(to_bcd(0));
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (bus.score !== 12'h000) begin
            n_bad++; $display("FAIL reset_score: got %h want 000", bus.score);
        end
        n_cmp++;
        if (bus.disp !== 12'hFF0) begin
            n_bad++; $display("FAIL reset_disp: got %h want FF0", bus.disp);
        end
        n_cmp++;
        if (bus.overflow !== 1'b0 || bus.new_high !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got ovf=%b nh=%b want 0 0",
                     bus.overflow, bus.new_high);
        end
`ifdef SCORE_HISCORE_EN
        exp_v = 12'hFF0;
`else
        exp_v = 12'hFFF;
`endif
        n_cmp++;
        if (bus.hi_disp !== exp_v) begin
            n_bad++; $display("FAIL reset_hi_disp: got %h want %h", bus.hi_disp, exp_v);
        end
    endtask

    task automatic test_count();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            do_inc();
            exp_v = q.pop_front();
            n_cmp++;
            if (bus.score !== exp_v) begin
                n_bad++; $display("FAIL count_score: got %h want %h", bus.score, exp_v);
            end
        end
        n_cmp++;
        if (bus.disp !== 12'hF12) begin
            n_bad++; $display("FAIL count_disp: got %h want F12", bus.disp);
        end
    endtask

    task automatic test_held();
        do_reset();
        @(negedge clk) bus.inc = 1'b1;
        repeat (20) @(negedge clk);
        bus.inc = 1'b0;
        repeat (2) @(negedge clk);
        m_score++;
        q.push_back(to_bcd(m_score));
        exp_v = q.pop_front();
        n_cmp++;
        if (bus.score !== exp_v) begin
            n_bad++; $display("FAIL held_once: got %h want %h", bus.score, exp_v);
        end
        reset_n = 1'b0;
        bus.inc = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        m_score = 0;
        repeat (3) @(negedge clk);
        bus.inc = 1'b0;
        repeat (2) @(negedge clk);
        q.push_back(to_bcd(m_score));
        exp_v = q.pop_front();
        n_cmp++;
        if (bus.score !== exp_v) begin
            n_bad++; $display("FAIL held_thru_reset: got %h want %h", bus.score, exp_v);
        end
    endtask

    task automatic test_carry_sat();
        do_reset();
        for (int i = 0; i < 99; i++) begin
            do_inc();
            exp_v = q.pop_front();
            n_cmp++;
            if (bus.score !== exp_v) begin
                n_bad++; $display("FAIL ramp_a: got %h want %h", bus.score, exp_v);
            end
        end
        n_cmp++;
        if (bus.disp !== 12'hF99) begin
            n_bad++; $display("FAIL disp_099: got %h want F99", bus.disp);
        end
        do_inc();
        exp_v = q.pop_front();
        n_cmp++;
        if (bus.score !== exp_v || bus.disp !== 12'h100) begin
            n_bad++;
            $display("FAIL carry_100: got %h/%h want %h/100", bus.score, bus.disp, exp_v);
        end
        for (int i = 0; i < 899; i++) begin
            do_inc();
            exp_v = q.pop_front();
            n_cmp++;
            if (bus.score !== exp_v) begin
                n_bad++; $display("FAIL ramp_b: got %h want %h", bus.score, exp_v);
            end
        end
        n_cmp++;
        if (bus.overflow !== 1'b0) begin
            n_bad++; $display("FAIL ovf_at_999: got %b want 0", bus.overflow);
        end
        for (int i = 0; i < 2; i++) begin
            do_inc();
            exp_v = q.pop_front();
            n_cmp++;
            if (bus.score !== exp_v || bus.overflow !== m_ovf) begin
                n_bad++;
                $display("FAIL saturate: got %h ovf=%b want %h ovf=%b",
                         bus.score, bus.overflow, exp_v, m_ovf);
            end
        end
        do_clear();
        exp_v = q.pop_front();
        n_cmp++;
        if (bus.score !== exp_v || bus.overflow !== 1'b0 || bus.disp !== 12'hFF0) begin
            n_bad++;
            $display("FAIL sat_clear: got %h ovf=%b disp=%h want %h 0 FF0",
                     bus.score, bus.overflow, bus.disp, exp_v);
        end
        do_inc();
        exp_v = q.pop_front();
        n_cmp++;
        if (bus.score !== exp_v) begin
            n_bad++; $display("FAIL run_after_clear: got %h want %h", bus.score, exp_v);
        end
    endtask

    task automatic test_clear_prio();
        do_reset();
        repeat (5) do_inc();
        q.delete();
        @(negedge clk);
        bus.clear = 1'b1;
        bus.inc = 1'b1;
        @(negedge clk) bus.clear = 1'b0;
        repeat (3) @(negedge clk);
        bus.inc = 1'b0;
        @(negedge clk);
        m_score = 0;
        q.push_back(to_bcd(m_score));
        exp_v = q.pop_front();
        n_cmp++;
        if (bus.score !== exp_v) begin
            n_bad++; $display("FAIL clear_prio: got %h want %h", bus.score, exp_v);
        end
        do_inc();
        exp_v = q.pop_front();
        n_cmp++;
        if (bus.score !== exp_v) begin
            n_bad++; $display("FAIL clear_then_inc: got %h want %h", bus.score, exp_v);
        end
    endtask

    task automatic test_hiscore();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            do_inc();
            exp_v = q.pop_front();
`ifndef SCORE_HISCORE_EN
            m_nh = 1'b0;
`endif
            n_cmp++;
            if (bus.score !== exp_v || bus.new_high !== m_nh) begin
                n_bad++;
                $display("FAIL hi_first: got %h nh=%b want %h nh=%b",
                         bus.score, bus.new_high, exp_v, m_nh);
            end
        end
        do_clear();
        void'(q.pop_front());
        for (int i = 0; i < 9; i++) begin
            do_inc();
            exp_v = q.pop_front();
`ifndef SCORE_HISCORE_EN
            m_nh = 1'b0;
`endif
            n_cmp++;
            if (bus.score !== exp_v || bus.new_high !== m_nh) begin
                n_bad++;
                $display("FAIL hi_second: got %h nh=%b want %h nh=%b",
                         bus.score, bus.new_high, exp_v, m_nh);
            end
        end
`ifdef SCORE_HISCORE_EN
        exp_v = 12'hFF9;
`else
        exp_v = 12'hFFF;
`endif
        n_cmp++;
        if (bus.hi_disp !== exp_v) begin
            n_bad++; $display("FAIL hi_disp: got %h want %h", bus.hi_disp, exp_v);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (3) do_inc();
        q.delete();
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.score !== 12'h000 || bus.disp !== 12'hFF0 ||
            bus.overflow !== 1'b0 || bus.new_high !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: got %h %h ovf=%b nh=%b want 000 FF0 0 0",
                     bus.score, bus.disp, bus.overflow, bus.new_high);
        end
`ifdef SCORE_HISCORE_EN
        exp_v = 12'hFF0;
`else
        exp_v = 12'hFFF;
`endif
        n_cmp++;
        if (bus.hi_disp !== exp_v) begin
            n_bad++; $display("FAIL async_hi_disp: got %h want %h", bus.hi_disp, exp_v);
        end
        @(negedge clk) reset_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset_n = 1'b0;
        bus.inc = 1'b0;
        bus.clear = 1'b0;
        test_reset();
        test_count();
        test_held();
        test_carry_sat();
        test_clear_prio();
        test_hiscore();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
